// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM port arbiter: requester indices and default widths.
package sdram_pkg;

    localparam int PORT_GPU = 0;
    localparam int PORT_APU = 1;
    localparam int PORT_CPU = 2;

    localparam int DEF_NUM_PORTS = 3;
    localparam int DEF_ADDR_W    = 24;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_TAG_DEPTH = 4;

    // Index width that stays legal for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Tag FIFO remembering which requester owns each outstanding read, in issue order.
module sdram_tag_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = DEF_TAG_DEPTH,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = idx_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem_q[rd_ptr_q];

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter with urgency override feeding one SDRAM command port; routes
// in-order read returns back to the requester that issued them.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS-1:0]             req_urgent,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [DATA_W-1:0]                rsp_data,
    output logic                             cmd_valid,
    output logic                             cmd_we,
    output logic [ADDR_W-1:0]                cmd_addr,
    output logic [DATA_W-1:0]                cmd_wdata,
    input  logic                             cmd_ready,
    input  logic                             rd_valid,
    input  logic [DATA_W-1:0]                rd_data,
    output logic                             err_underflow
);

    localparam int PORT_W = idx_w(NUM_PORTS);

    logic [PORT_W-1:0]    last_grant_q;
    logic                 cmd_valid_q, cmd_we_q;
    logic [ADDR_W-1:0]    cmd_addr_q;
    logic [DATA_W-1:0]    cmd_wdata_q;
    logic                 err_underflow_q;

    logic [NUM_PORTS-1:0] eligible, cand;
    logic                 win_found, capture, cmd_free;
    logic [PORT_W-1:0]    win_idx, rr_sel;
    int                   rr_idx;
    logic                 tags_full, tags_empty, tag_push, tag_pop;
    logic [PORT_W-1:0]    tag_head;

    assign eligible = req_valid & (req_we | {NUM_PORTS{!tags_full}});
    assign cand     = (|(eligible & req_urgent)) ? (eligible & req_urgent) : eligible;

    // NOTE: combinational logic uses blocking assignments and gives every output a default
    // first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
        rr_sel    = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            rr_idx = (int'(last_grant_q) + k) % NUM_PORTS;
            rr_sel = PORT_W'(rr_idx);
            if (!win_found && cand[rr_sel]) begin
                win_found = 1'b1;
                win_idx   = rr_sel;
            end
        end
    end

    assign cmd_free  = !cmd_valid_q || cmd_ready;
    assign capture   = !reset && cmd_free && win_found;
    assign req_ready = capture ? (NUM_PORTS'(1) << win_idx) : '0;

    assign tag_push  = capture && !req_we[win_idx];
    assign tag_pop   = !reset && rd_valid && !tags_empty;
    assign rsp_valid = tag_pop ? (NUM_PORTS'(1) << tag_head) : '0;
    assign rsp_data  = rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid_q     <= 1'b0;
            cmd_we_q        <= 1'b0;
            cmd_addr_q      <= '0;
            cmd_wdata_q     <= '0;
            last_grant_q    <= PORT_W'(NUM_PORTS - 1);
            err_underflow_q <= 1'b0;
        end else begin
            if (capture) begin
                cmd_valid_q  <= 1'b1;
                cmd_we_q     <= req_we[win_idx];
                cmd_addr_q   <= req_addr[win_idx];
                cmd_wdata_q  <= req_wdata[win_idx];
                last_grant_q <= win_idx;
            end else if (cmd_ready) begin
                cmd_valid_q <= 1'b0;
            end
            if (rd_valid && tags_empty) err_underflow_q <= 1'b1;
        end
    end

    assign cmd_valid     = cmd_valid_q;
    assign cmd_we        = cmd_we_q;
    assign cmd_addr      = cmd_addr_q;
    assign cmd_wdata     = cmd_wdata_q;
    assign err_underflow = err_underflow_q;

    sdram_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (PORT_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tag_push),
        .push_data (win_idx),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .full      (tags_full),
        .empty     (tags_empty)
    );

endmodule
